data_mem_lsu: RTL and testbench

Parametrised, byte-addressable data memory for the RISC-V cores, with an integrated load/store unit. It replaces the fixed 4 KB word-only data memory and sits between the core's memory stage and on-chip SRAM. Supported accesses:
- Byte, halfword and word loads and stores, with sign or zero extension.
- Misaligned and out-of-range fault reporting.
- A valid/ready request port with a registered 1-cycle response.
- Sequential post-reset clearing, one word per cycle, so the array maps to RAM instead of a flop bank.

---
 rtl/data_mem_lsu.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   Byte-addressable data memory with an integrated load/store unit for the
//   RISC-V cores. Requests arrive on a valid/ready port, stores commit at the
//   acceptance edge, and every accepted request produces a one-cycle response
//   on the following cycle. After reset the array is optionally cleared one
//   word per cycle, which keeps the storage mappable to a single-port RAM.
//
// Ports
//   clk           clock
//   reset         asynchronous active-high reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle (RUN state)
//   req_we        1 = store, 0 = load
//   req_addr      byte address
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata     store data, right-aligned
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data, 0 for stores and faults
//   rsp_fault     request rejected, qualified by rsp_valid
//   init_done     clearing finished (level)
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter bit INIT_CLEAR  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] clr_idx, clr_idx_next;
    logic             clear_we;

    logic [3:0][7:0]  mem [DEPTH_WORDS];

    logic [IDX_W-1:0] req_idx;
    logic [1:0]       lane;
    logic             fault;
    logic             accept;
    logic [3:0]       store_be;
    logic [31:0]      store_data;

    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [IDX_W-1:0] mem_idx;

    logic [31:0]      rd_word_p1;
    logic             vld_p1;
    logic             load_p1;
    logic             fault_p1;
    logic [1:0]       lane_p1;
    logic [1:0]       size_p1;
    logic             uns_p1;

    // Align the addressed lane to bit 0, truncate to the access size, extend.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  ln,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] sh;
        sh = word >> {ln, 3'b000};
        case (size)
            2'b00:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        clear_we     = 1'b0;
        req_ready    = 1'b0;
        init_done    = 1'b0;
        case (state)
            INIT: begin
                if (INIT_CLEAR) begin
                    clear_we     = 1'b1;
                    clr_idx_next = clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(DEPTH_WORDS - 1))
                        state_next = RUN;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        req_idx = req_addr[IDX_W+1:2];
        lane    = req_addr[1:0];
        accept  = req_valid && req_ready;

        fault = ((req_addr >> (IDX_W + 2)) != 32'd0)
             || (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

        case (req_size)
            2'b00: begin
                store_be   = 4'b0001 << lane;
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_be   = 4'b0011 << lane;
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = req_wdata;
            end
        endcase

        // The clear walk owns the single RAM port while in INIT.
        mem_we    = clear_we || (accept && req_we && !fault);
        mem_be    = clear_we ? 4'b1111 : store_be;
        mem_wdata = clear_we ? 32'h0 : store_data;
        mem_idx   = clear_we ? clr_idx : req_idx;
    end

    // ---- stage p0 -> p1: RAM access and request capture ----
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b])
                mem[mem_idx][b] <= mem_wdata[8*b +: 8];
        end
        rd_word_p1 <= mem[mem_idx];
        load_p1    <= !req_we;
        fault_p1   <= fault;
        lane_p1    <= lane;
        size_p1    <= req_size;
        uns_p1     <= req_unsigned;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept;
    end

    // ---- stage p1: response formatting ----
    always_comb begin
        rsp_valid = vld_p1;
        rsp_fault = vld_p1 && fault_p1;
        rsp_rdata = 32'h0;
        if (vld_p1 && load_p1 && !fault_p1)
            rsp_rdata = load_extend(rd_word_p1, lane_p1, size_p1, uns_p1);
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu
//   Scoreboard bench for data_mem_lsu. The driver pushes the expected response
//   of each accepted request into a queue; a monitor on the falling edge pops
//   and compares whenever rsp_valid is high. Expected values come from explicit
//   constants for the directed cases and from a byte-array memory model for
//   the randomized traffic.
module tb_data_mem_lsu;

    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [4*DEPTH];
    exp_t       sb [$];

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .init_done    (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as a flat byte array, accesses as byte loops.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [1:0] size, input logic uns,
                                   input logic [31:0] wdata);
        exp_t        r;
        int          n;
        int          a;
        logic [31:0] v;
        n = 1 << size;
        r.rdata = 32'h0;
        r.fault = 1'b0;
        if (size == 2'd3 || addr >= 32'(4*DEPTH) || (addr % 32'(n)) != 0) begin
            r.fault = 1'b1;
            return r;
        end
        a = int'(addr);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a+i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a+i];
            if (!uns && n < 4 && v[8*n-1])
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            r.rdata = v;
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         input bit use_exp, input logic [31:0] exp_d, input logic exp_f);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        check("req_ready_before_issue", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        e = model(we, addr, size, uns, wdata);
        if (use_exp) begin
            e.rdata = exp_d;
            e.fault = exp_f;
        end
        sb.push_back(e);
        #1;
        req_valid = 1'b0;
        check("rsp_valid_after_accept", {31'h0, rsp_valid}, 32'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h0);
        check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_rsp_fault"}, {31'h0, rsp_fault}, 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_init_done"}, {31'h0, init_done}, 32'h0);
    endtask

    // Releases reset at posedge+1 and counts edges until req_ready rises.
    task automatic release_and_count();
        int cnt;
        reset = 1'b0;
        cnt = 0;
        while (!req_ready && cnt < DEPTH + 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("init_cycles", cnt, DEPTH);
        check("init_done_level", {31'h0, init_done}, 32'h1);
        clear_model();
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with no pending request, rdata %h at %0t",
                         rsp_rdata, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_fault", {31'h0, rsp_fault}, {31'h0, e.fault});
            end
        end
    end

    initial begin
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;

        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        release_and_count();

        issue(1'b0, 32'h0,   2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        issue(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        idle(1);

        issue(1'b1, 32'h10, 2'b10, 1'b0, 32'h8000_00FF, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 2'b00, 1'b0, 32'h0, 1, 32'hFFFF_FFFF, 1'b0);
        issue(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 1, 32'h0000_0080, 1'b0);
        idle(1);

        issue(1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344, 1, 32'h0, 1'b0);
        issue(1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_00AA, 1, 32'h0, 1'b0);
        issue(1'b1, 32'h22, 2'b01, 1'b0, 32'h0000_BEEF, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1, 32'hBEEF_AA44, 1'b0);
        idle(1);

        issue(1'b0, 32'h21, 2'b01, 1'b0, 32'h0, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h22, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h0,  2'b11, 1'b0, 32'h0, 1, 32'h0, 1'b1);
        issue(1'b1, 32'(4*DEPTH), 2'b10, 1'b0, 32'hCAFE_BABE, 1, 32'h0, 1'b1);
        issue(1'b1, 32'h22, 2'b10, 1'b0, 32'h5555_5555, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1, 32'hBEEF_AA44, 1'b0);
        issue(1'b0, 32'h0,  2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        idle(1);

        issue(1'b1, 32'h40, 2'b10, 1'b0, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
        idle(1);

        for (int k = 0; k < 400; k++) begin
            we   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && size != 2'b11)
                addr = addr & ~((32'd1 << size) - 32'd1);
            issue(we, addr, size, 1'($urandom_range(0, 1)), $urandom, 0, 32'h0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        check("scoreboard_drained", sb.size(), 0);

        // Store, then reset while the following load's response is in flight.
        issue(1'b1, 32'h40, 2'b10, 1'b0, 32'h1234_5678, 1, 32'h0, 1'b0);
        idle(1);
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midstream");
        sb.delete();
        idle(1);
        release_and_count();
        issue(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 2'b10, 1'b0, 32'hA5A5_5A5A, 1, 32'h0, 1'b0);
        idle(1);

        // Reset in the middle of the clear walk, after 100 words.
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(100);
        check("ready_mid_init", {31'h0, req_ready}, 32'h0);
        reset = 1'b1;
        #1;
        check_reset_outputs("midinit");
        idle(1);
        release_and_count();
        issue(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        issue(1'b0, 32'hFFC, 2'b10, 1'b0, 32'h0, 1, 32'h0, 1'b0);
        idle(3);
        check("final_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
